// File: rtl/alu_req_sequencer.sv
// Single-transaction request/response driver for the Alu_f datapath.
// Latency: response valid LAT+1 cycles after request accept (LAT = LAT_STD, or LAT_MUL for multiply).
// Backpressure: req_ready only in IDLE; response held stable until rsp_ready. ALU_SEQ_STATS_EN adds stat_txn/stat_err.
module alu_req_sequencer #(
    parameter int WIDTH   = 8,
    parameter int C_WIDTH = 4,
    parameter int LAT_STD = 1,
    parameter int LAT_MUL = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [WIDTH-1:0]     req_opa,
    input  logic [WIDTH-1:0]     req_opb,
    input  logic                 req_cin,
    input  logic                 req_mode,
    input  logic [C_WIDTH-1:0]   req_cmd,
    input  logic [1:0]           req_inv,
    output logic [WIDTH-1:0]     ALU_OPA,
    output logic [WIDTH-1:0]     ALU_OPB,
    output logic                 ALU_CIN,
    output logic                 ALU_MODE,
    output logic                 ALU_CE,
    output logic [C_WIDTH-1:0]   ALU_CMD,
    output logic [1:0]           ALU_IN_VALID,
    input  logic [WIDTH:0]       ALU_RES,
    input  logic [2*WIDTH-1:0]   ALU_MUL_RES,
    input  logic [5:0]           ALU_FLAGS,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WIDTH:0]       rsp_res,
    output logic [2*WIDTH-1:0]   rsp_mul,
    output logic [5:0]           rsp_flags
`ifdef ALU_SEQ_STATS_EN
    ,
    output logic [15:0]          stat_txn,
    output logic [15:0]          stat_err
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAT_STD_C = 4'(LAT_STD);
    localparam logic [3:0] LAT_MUL_C = 4'(LAT_MUL);

    state_t     state;
    logic [3:0] cnt;
    logic       req_is_mul;

    // Multiply commands only exist in arithmetic mode; logical cmd 9/10 use the standard latency.
    always_comb begin
        req_is_mul = req_mode && ((req_cmd == C_WIDTH'(9)) || (req_cmd == C_WIDTH'(10)));
    end

    // Sequencer FSM: issue operands, count down ALU latency, capture and hold the response.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            req_ready    <= 1'b1;
            ALU_OPA      <= '0;
            ALU_OPB      <= '0;
            ALU_CIN      <= 1'b0;
            ALU_MODE     <= 1'b0;
            ALU_CE       <= 1'b0;
            ALU_CMD      <= '0;
            ALU_IN_VALID <= 2'b00;
            rsp_valid    <= 1'b0;
            rsp_res      <= '0;
            rsp_mul      <= '0;
            rsp_flags    <= 6'd0;
`ifdef ALU_SEQ_STATS_EN
            stat_txn     <= 16'd0;
            stat_err     <= 16'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        ALU_OPA      <= req_opa;
                        ALU_OPB      <= req_opb;
                        ALU_CIN      <= req_cin;
                        ALU_MODE     <= req_mode;
                        ALU_CMD      <= req_cmd;
                        ALU_IN_VALID <= req_inv;
                        ALU_CE       <= 1'b1;
                        req_ready    <= 1'b0;
                        cnt          <= req_is_mul ? LAT_MUL_C : LAT_STD_C;
                        state        <= BUSY;
                    end
                end
                BUSY: begin
                    // Operands stay put; result is sampled one edge after the countdown expires.
                    if (cnt == 4'd0) begin
                        rsp_res      <= ALU_RES;
                        rsp_mul      <= ALU_MUL_RES;
                        rsp_flags    <= ALU_FLAGS;
                        rsp_valid    <= 1'b1;
                        ALU_CE       <= 1'b0;
                        ALU_IN_VALID <= 2'b00;
                        state        <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    // Response data is retained after the handshake; only valid drops.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
`ifdef ALU_SEQ_STATS_EN
                        if (stat_txn != 16'hFFFF) stat_txn <= stat_txn + 16'd1;
                        if (rsp_flags[0] && (stat_err != 16'hFFFF)) stat_err <= stat_err + 16'd1;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_sequencer.sv
// Directed bench for alu_req_sequencer with a behavioural ALU stub whose outputs become valid
// only after a programmable number of enabled cycles; before that it drives garbage.
// Covers reset, ADD/MUL/logical latency, backpressure, error flag, mid-transaction reset and stats.
module tb_alu_req_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_opa, req_opb;
    logic        req_cin, req_mode;
    logic [3:0]  req_cmd;
    logic [1:0]  req_inv;
    logic [7:0]  ALU_OPA, ALU_OPB;
    logic        ALU_CIN, ALU_MODE, ALU_CE;
    logic [3:0]  ALU_CMD;
    logic [1:0]  ALU_IN_VALID;
    logic [8:0]  ALU_RES;
    logic [15:0] ALU_MUL_RES;
    logic [5:0]  ALU_FLAGS;
    logic        rsp_valid, rsp_ready;
    logic [8:0]  rsp_res;
    logic [15:0] rsp_mul;
    logic [5:0]  rsp_flags;
`ifdef ALU_SEQ_STATS_EN
    logic [15:0] stat_txn, stat_err;
`endif

    int checks = 0;
    int errors = 0;

    // ALU stub state
    logic [3:0]  stub_lat;
    logic [8:0]  stub_res;
    logic [15:0] stub_mul;
    logic [5:0]  stub_flags;
    int          stub_cnt;

    alu_req_sequencer #(.WIDTH(8), .C_WIDTH(4), .LAT_STD(1), .LAT_MUL(2)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opa(req_opa), .req_opb(req_opb), .req_cin(req_cin),
        .req_mode(req_mode), .req_cmd(req_cmd), .req_inv(req_inv),
        .ALU_OPA(ALU_OPA), .ALU_OPB(ALU_OPB), .ALU_CIN(ALU_CIN),
        .ALU_MODE(ALU_MODE), .ALU_CE(ALU_CE), .ALU_CMD(ALU_CMD),
        .ALU_IN_VALID(ALU_IN_VALID),
        .ALU_RES(ALU_RES), .ALU_MUL_RES(ALU_MUL_RES), .ALU_FLAGS(ALU_FLAGS),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_res(rsp_res), .rsp_mul(rsp_mul), .rsp_flags(rsp_flags)
`ifdef ALU_SEQ_STATS_EN
        ,
        .stat_txn(stat_txn), .stat_err(stat_err)
`endif
    );

    always #5 CLK = ~CLK;

    // Stub counts enabled cycles; results are valid once the count reaches the programmed latency.
    always @(posedge CLK or posedge RST) begin
        if (RST) stub_cnt <= 0;
        else     stub_cnt <= ALU_CE ? stub_cnt + 1 : 0;
    end

    assign ALU_RES     = (stub_cnt >= int'(stub_lat)) ? stub_res   : 9'h1AA;
    assign ALU_MUL_RES = (stub_cnt >= int'(stub_lat)) ? stub_mul   : 16'hDEAD;
    assign ALU_FLAGS   = (stub_cnt >= int'(stub_lat)) ? stub_flags : 6'h2A;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [7:0] a, input logic [7:0] b, input logic m,
                           input logic [3:0] c, input logic [1:0] inv);
        req_opa  = a;
        req_opb  = b;
        req_mode = m;
        req_cmd  = c;
        req_inv  = inv;
        req_cin  = 1'b0;
    endtask

    task automatic set_stub(input logic [3:0] lat, input logic [8:0] r,
                            input logic [15:0] mr, input logic [5:0] f);
        stub_lat   = lat;
        stub_res   = r;
        stub_mul   = mr;
        stub_flags = f;
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        set_req(8'h00, 8'h00, 1'b0, 4'h0, 2'b00);
        set_stub(4'd1, 9'h000, 16'h0000, 6'h00);
        tick();
        tick();

        // Reset state
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_alu_ce", 32'(ALU_CE), 32'd0);
        chk("rst_alu_opa", 32'(ALU_OPA), 32'd0);
        chk("rst_alu_inv", 32'(ALU_IN_VALID), 32'd0);
        chk("rst_rsp_res", 32'(rsp_res), 32'd0);
`ifdef ALU_SEQ_STATS_EN
        chk("rst_stat_txn", 32'(stat_txn), 32'd0);
`endif
        RST = 1'b0;
        tick();

        // rsp_ready while idle has no effect
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("idle_rdy_req_ready", 32'(req_ready), 32'd1);
        chk("idle_rdy_rsp_valid", 32'(rsp_valid), 32'd0);

        // ADD: LAT_STD=1 -> response at accept+2
        set_req(8'h0F, 8'h02, 1'b1, 4'd0, 2'b11);
        set_stub(4'd1, 9'h011, 16'h0000, 6'h00);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("add_acc_req_ready", 32'(req_ready), 32'd0);
        chk("add_acc_ce", 32'(ALU_CE), 32'd1);
        chk("add_acc_opa", 32'(ALU_OPA), 32'h0F);
        chk("add_acc_opb", 32'(ALU_OPB), 32'h02);
        chk("add_acc_inv", 32'(ALU_IN_VALID), 32'h3);
        tick();
        chk("add_p1_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("add_p1_ce", 32'(ALU_CE), 32'd1);
        tick();
        chk("add_p2_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("add_rsp_res", 32'(rsp_res), 32'h011);
        chk("add_rsp_flags", 32'(rsp_flags), 32'h00);
        chk("add_p2_ce", 32'(ALU_CE), 32'd0);
        chk("add_p2_inv", 32'(ALU_IN_VALID), 32'd0);
        chk("add_p2_opa_hold", 32'(ALU_OPA), 32'h0F);
        handshake();
        chk("add_hs_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("add_hs_req_ready", 32'(req_ready), 32'd1);
        chk("add_hs_res_kept", 32'(rsp_res), 32'h011);

        // MUL: LAT_MUL=2 -> response at accept+3
        set_req(8'h06, 8'h08, 1'b1, 4'd9, 2'b11);
        set_stub(4'd2, 9'h030, 16'h0030, 6'h00);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        chk("mul_p2_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        chk("mul_p3_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("mul_rsp_mul", 32'(rsp_mul), 32'h0030);
        handshake();

        // Logical cmd 9 uses LAT_STD
        set_req(8'hF0, 8'h0F, 1'b0, 4'd9, 2'b11);
        set_stub(4'd1, 9'h0F0, 16'h0000, 6'b100000);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        chk("log_p1_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        chk("log_p2_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("log_rsp_res", 32'(rsp_res), 32'h0F0);
        chk("log_rsp_flags", 32'(rsp_flags), 32'h20);
        handshake();

        // Error flag with 5 cycles of backpressure and a pending second request
        set_req(8'h11, 8'h22, 1'b1, 4'd1, 2'b01);
        set_stub(4'd1, 9'h1FF, 16'h0000, 6'b000001);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        chk("err_rsp_valid", 32'(rsp_valid), 32'd1);
        set_req(8'h55, 8'h01, 1'b1, 4'd0, 2'b11);
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_res", 32'(rsp_res), 32'h1FF);
            chk("bp_rsp_flags", 32'(rsp_flags), 32'h01);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_opa_hold", 32'(ALU_OPA), 32'h11);
        end
        set_stub(4'd1, 9'h056, 16'h0000, 6'h00);
        handshake();
        chk("bp_hs_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("bp_hs_req_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        chk("bp_second_acc_opa", 32'(ALU_OPA), 32'h55);
        chk("bp_second_acc_ce", 32'(ALU_CE), 32'd1);
        tick();
        tick();
        chk("second_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("second_rsp_res", 32'(rsp_res), 32'h056);
        handshake();
`ifdef ALU_SEQ_STATS_EN
        chk("stat_txn", 32'(stat_txn), 32'd5);
        chk("stat_err", 32'(stat_err), 32'd1);
`endif

        // Reset mid-BUSY aborts the transaction
        set_req(8'h07, 8'h03, 1'b1, 4'd10, 2'b11);
        set_stub(4'd2, 9'h015, 16'h0015, 6'h00);
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        chk("abort_busy_ce", 32'(ALU_CE), 32'd1);
        RST = 1'b1;
        #1;
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_ce", 32'(ALU_CE), 32'd0);
        chk("abort_opa", 32'(ALU_OPA), 32'd0);
        chk("abort_rsp_res", 32'(rsp_res), 32'd0);
        tick();
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end
        chk("abort_idle_ready", 32'(req_ready), 32'd1);
`ifdef ALU_SEQ_STATS_EN
        chk("abort_stat_txn", 32'(stat_txn), 32'd0);
        chk("abort_stat_err", 32'(stat_err), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
